// File: rtl/seq_mult_fxp.sv
// seq_mult_fxp: multi-cycle signed fixed-point multiplier.
// Radix-2 shift-add with one multiplier bit retired per clock. The multiplier
// sign bit carries weight -2^(B_W-1), so the final iteration subtracts its
// partial product instead of adding it. That yields the exact
// two's-complement product in P_W = A_W + B_W bits.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. A producer holds its data stable while valid
// is high and ready is low. in_ready and out_valid are registered and follow
// the FSM state only. Neither has a combinational path from any input.
module seq_mult_fxp #(
  parameter int A_W = 10,
  parameter int B_W = 9,
  parameter int P_W = 19
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] data_a,
  input  logic [B_W-1:0] data_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] product
);

  // The product width must hold every A_W x B_W signed product exactly.
  generate
    if (P_W != A_W + B_W) begin : g_bad_cfg
      $error("seq_mult_fxp: P_W (%0d) must equal A_W + B_W (%0d)", P_W, A_W + B_W);
    end
  endgenerate

  // Iteration counter width; holds 0 .. B_W-1.
  localparam int K_W = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(B_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [P_W-1:0] a_ext;     // multiplicand sign-extended to product width
  logic [B_W-1:0] b_sh;      // multiplier, shifted right so bit k sits at [0]
  logic [P_W-1:0] acc;       // running partial sum, modulo 2^P_W
  logic [K_W-1:0] k;         // index of the multiplier bit being retired
  logic [P_W-1:0] addend;    // a_ext << k, upper bits dropped
  logic [P_W-1:0] acc_next;  // accumulator after the current iteration

  // Partial product for this iteration. The sign bit subtracts.
  always_comb begin
    addend   = a_ext << k;
    acc_next = acc;
    if (b_sh[0]) begin
      if (k == K_LAST) begin
        acc_next = acc - addend;
      end else begin
        acc_next = acc + addend;
      end
    end
  end

  // Control FSM and datapath registers. rst overrides any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      acc       <= '0;
      k         <= '0;
      a_ext     <= '0;
      b_sh      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_ext    <= {{(P_W - A_W){data_a[A_W-1]}}, data_a};
            b_sh     <= data_b;
            acc      <= '0;
            k        <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
          end
        end
        CALC: begin
          // in_valid is ignored here; in_ready is already low.
          acc  <= acc_next;
          b_sh <= b_sh >> 1;
          if (k == K_LAST) begin
            product   <= acc_next;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          // The product stays put until the consumer takes it. The return to
          // IDLE costs one edge, so no operand can be accepted on the same
          // edge as the output handshake.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
